alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for core_lapido, successor of the combinational alu.
//  Keeps every single-cycle FN_* op. Adds iterative unsigned MUL/DIV/REM and barrel shifts by N.
//  Sits in EX behind a valid/ready handshake, so EX stalls only while a mul/div iterates.
// PARAMETERS
//  WIDTH    32  operand/result width; >=4, even
//  FUNCT_W  6   width of alu_funct (FN_* codes from lapido_defs.v)
// PORTS
//  clk        in   1          clock; single clock domain, rising edge
//  rst        in   1          reset; synchronous, active-high
//  in_valid   in   1          op1/op2/alu_funct valid
//  in_ready   out  1          unit can accept an operation this cycle
//  op1        in   WIDTH      first operand (rs)
//  op2        in   WIDTH      second operand (rt / shift amount)
//  alu_funct  in   FUNCT_W    operation code
//  out_valid  out  1          alu_res/flags valid
//  out_ready  in   1          consumer takes result this cycle
//  alu_res    out  WIDTH+1    result; bit WIDTH = carry
//  flags      out  5          [`FL_ZERO,`FL_TRUE,`FL_NEG,`FL_OVERFLOW,`FL_NEGZERO]
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, alu_res=0, flags=0; in_ready=1 the cycle after rst drops.
//  rst mid-operation aborts any iteration. The result is discarded, with no late out_valid.
//  FSM states: IDLE, BUSY, DONE.
//   IDLE -> DONE on accept of a single-cycle op. Latency 1.
//   IDLE -> BUSY on accept of MUL/DIV/REM. Counter loads WIDTH.
//   BUSY: one bit per cycle; counter decrements; -> DONE when it reaches 0. Latency WIDTH+1.
//   DONE -> IDLE when out_ready=1 and in_valid=0.
//   DONE -> DONE or BUSY when out_ready=1 and in_valid=1, per the new op (back-to-back accept).
//  Ops:
//   accept     = in_valid & in_ready
//   in_ready   = (state==IDLE) | (state==DONE & out_ready); combinational.
//   Operands and funct are registered on accept. Inputs are ignored at all other times.
//   out_valid  = (state==DONE). While out_valid & !out_ready, alu_res/flags are held stable.
//  Single-cycle ops (signed two's complement):
//   ADD, SUB: carry = bit WIDTH of the unsigned (WIDTH+1)-bit sum/difference.
//   ASL/ASR/LSL/LSR: shift by 1.
//   AND, NAND, OR, NOR, XOR, XNOR, NOT(op1): bit-wise.
//   SLT: res = (op1<op2 signed) ? 1 : 0.
//  New ops:
//   SHLV/SHRV/SRAV: shift op1 by op2[$clog2(WIDTH)-1:0]; single-cycle barrel.
//   MUL: low WIDTH bits of the unsigned product, shift-add.
//   DIV/REM: unsigned restoring quotient/remainder.
//  Carry (bit WIDTH) is 0 for all non-ADD/SUB ops.
//  Flags, computed on r = alu_res[WIDTH-1:0]:
//   ZERO    = (r==0)
//   TRUE    = 1
//   NEG     = r[WIDTH-1]
//   NEGZERO = NEG|ZERO
//   OVERFLOW: ADD/SUB = signed overflow; MUL = product high half !=0; DIV/REM = op2==0; else 0.
//  Divide by zero: DIV -> all ones, REM -> op1, OVERFLOW=1. Still takes WIDTH+1 cycles.
//  Unknown alu_funct: res=0, flags per rule above (ZERO=1), latency 1.
// STRUCTURE
//  lapido_defs.v (shared):
//   existing FN_*/FL_* defines;
//   new FN_MUL, FN_DIV, FN_REM, FN_SHLV, FN_SHRV, FN_SRAV codes, distinct from existing codes;
//   ALU state encodings.
//  Sub-module alu_muldiv_iter (start, is_div, a, b -> busy, done, q/prod, rem):
//   holds the accumulator/remainder registers and the iteration counter.
//  alu_mc owns the FSM, single-cycle datapath, flag logic and output registers.
// TESTING  (WIDTH=32)
//  ADD 7FFFFFFF+1, out_ready=1 -> out_valid 1 cycle after accept; res=80000000, OVERFLOW=1, NEG=1, carry=0.
//  SUB 5-5 -> res=0, ZERO=1, NEGZERO=1, carry=0.
//  MUL 12345*1000 -> out_valid exactly 33 cycles after accept; res=12345000; in_ready=0 for cycles 1..32.
//  DIV 100/7 then REM 100/7 back-to-back, out_ready=1 -> results 14 and 2; second op accepted in the first op's DONE cycle.
//  DIV 5/0 -> res=FFFFFFFF, OVERFLOW=1; REM 5/0 -> res=5.
//  Hold out_ready=0 for 5 cycles after an ADD -> alu_res/flags stable, in_ready=0.
//  Assert rst at BUSY cycle 10 of a MUL -> next cycle out_valid=0; no later out_valid without a new accept.
//  SRAV 80000000 by 31 -> FFFFFFFF.
//  SHLV 1 by 32 -> op2[4:0]=0, so res=1.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared codes for the multi-cycle ALU: operation codes, flag bit positions
// and FSM state encodings.
package alu_mc_pkg;

  localparam logic [5:0] FN_ADD  = 6'h00;
  localparam logic [5:0] FN_SUB  = 6'h01;
  localparam logic [5:0] FN_ASL  = 6'h02;
  localparam logic [5:0] FN_ASR  = 6'h03;
  localparam logic [5:0] FN_LSL  = 6'h04;
  localparam logic [5:0] FN_LSR  = 6'h05;
  localparam logic [5:0] FN_AND  = 6'h06;
  localparam logic [5:0] FN_NAND = 6'h07;
  localparam logic [5:0] FN_OR   = 6'h08;
  localparam logic [5:0] FN_NOR  = 6'h09;
  localparam logic [5:0] FN_XOR  = 6'h0A;
  localparam logic [5:0] FN_XNOR = 6'h0B;
  localparam logic [5:0] FN_NOT  = 6'h0C;
  localparam logic [5:0] FN_SLT  = 6'h0D;
  localparam logic [5:0] FN_MUL  = 6'h0E;
  localparam logic [5:0] FN_DIV  = 6'h0F;
  localparam logic [5:0] FN_REM  = 6'h10;
  localparam logic [5:0] FN_SHLV = 6'h11;
  localparam logic [5:0] FN_SHRV = 6'h12;
  localparam logic [5:0] FN_SRAV = 6'h13;

  localparam int FL_ZERO     = 0;
  localparam int FL_TRUE     = 1;
  localparam int FL_NEG      = 2;
  localparam int FL_OVERFLOW = 3;
  localparam int FL_NEGZERO  = 4;

  typedef logic [4:0] alu_flags_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mc_if.sv
// Operation/result handshake between EX and the multi-cycle ALU.
interface alu_mc_if #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [FUNCT_W-1:0] alu_funct;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH:0]     alu_res;
  logic [4:0]         flags;

  modport master (
    output in_valid, op1, op2, alu_funct, out_ready,
    input  in_ready, out_valid, alu_res, flags
  );

  modport slave (
    input  in_valid, op1, op2, alu_funct, out_ready,
    output in_ready, out_valid, alu_res, flags
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// q_prod/rem_hi present the result of the step being taken this cycle.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q_prod,
  output logic [WIDTH-1:0] rem_hi
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;
  logic             is_div_reg;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;

  // hi:lo is the product accumulator for MUL and remainder:quotient for DIV
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - b_reg;
    if (is_div_reg) begin
      if (div_shift >= {1'b0, b_reg}) begin
        hi_next = div_diff;
        lo_next = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = div_shift[WIDTH-1:0];
        lo_next = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  assign busy   = (cnt_reg != '0);
  assign done   = (cnt_reg == CNT_W'(1));
  assign q_prod = lo_next;
  assign rem_hi = hi_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      b_reg      <= '0;
      is_div_reg <= 1'b0;
    end else if (start) begin
      cnt_reg    <= CNT_W'(WIDTH);
      hi_reg     <= '0;
      lo_reg     <= a;
      b_reg      <= b;
      is_div_reg <= is_div;
    end else if (busy) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops complete in one cycle, MUL/DIV/REM iterate
// WIDTH cycles in alu_muldiv_iter; result held until the consumer takes it.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  alu_mc_if.slave   bus
);
  localparam int SH_W = $clog2(WIDTH);

  logic [1:0]         state_reg;
  logic [WIDTH:0]     alu_res_reg;
  alu_flags_t         flags_reg;
  logic [FUNCT_W-1:0] funct_reg;
  logic               div0_reg;

  logic               accept, is_iter;
  logic [WIDTH:0]     add_sum, sub_diff, sc_res;
  logic               sc_ovf;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   sra_one, srav_res;
  logic               iter_busy, iter_done;
  logic [WIDTH-1:0]   iter_q, iter_rem, iter_res;
  logic               iter_ovf;

  function automatic alu_flags_t mk_flags(input logic [WIDTH-1:0] r, input logic ovf);
    alu_flags_t f;
    f[FL_ZERO]     = (r == '0);
    f[FL_TRUE]     = 1'b1;
    f[FL_NEG]      = r[WIDTH-1];
    f[FL_OVERFLOW] = ovf;
    f[FL_NEGZERO]  = f[FL_NEG] | f[FL_ZERO];
    return f;
  endfunction

  assign bus.in_ready  = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & bus.out_ready);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.alu_res   = alu_res_reg;
  assign bus.flags     = flags_reg;

  assign accept  = bus.in_valid & bus.in_ready;
  assign is_iter = (bus.alu_funct == FUNCT_W'(FN_MUL)) | (bus.alu_funct == FUNCT_W'(FN_DIV)) |
                   (bus.alu_funct == FUNCT_W'(FN_REM));

  assign add_sum  = {1'b0, bus.op1} + {1'b0, bus.op2};
  assign sub_diff = {1'b0, bus.op1} - {1'b0, bus.op2};
  assign shamt    = bus.op2[SH_W-1:0];
  assign sra_one  = $signed(bus.op1) >>> 1;
  assign srav_res = $signed(bus.op1) >>> shamt;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (bus.alu_funct)
      FUNCT_W'(FN_ADD): begin
        sc_res = add_sum;
        sc_ovf = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) & (add_sum[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      FUNCT_W'(FN_SUB): begin
        sc_res = sub_diff;
        sc_ovf = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) & (sub_diff[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      FUNCT_W'(FN_ASL), FUNCT_W'(FN_LSL): sc_res = {1'b0, bus.op1 << 1};
      FUNCT_W'(FN_ASR):  sc_res = {1'b0, sra_one};
      FUNCT_W'(FN_LSR):  sc_res = {1'b0, bus.op1 >> 1};
      FUNCT_W'(FN_AND):  sc_res = {1'b0, bus.op1 & bus.op2};
      FUNCT_W'(FN_NAND): sc_res = {1'b0, ~(bus.op1 & bus.op2)};
      FUNCT_W'(FN_OR):   sc_res = {1'b0, bus.op1 | bus.op2};
      FUNCT_W'(FN_NOR):  sc_res = {1'b0, ~(bus.op1 | bus.op2)};
      FUNCT_W'(FN_XOR):  sc_res = {1'b0, bus.op1 ^ bus.op2};
      FUNCT_W'(FN_XNOR): sc_res = {1'b0, ~(bus.op1 ^ bus.op2)};
      FUNCT_W'(FN_NOT):  sc_res = {1'b0, ~bus.op1};
      FUNCT_W'(FN_SLT):  sc_res = (WIDTH+1)'($signed(bus.op1) < $signed(bus.op2));
      FUNCT_W'(FN_SHLV): sc_res = {1'b0, bus.op1 << shamt};
      FUNCT_W'(FN_SHRV): sc_res = {1'b0, bus.op1 >> shamt};
      FUNCT_W'(FN_SRAV): sc_res = {1'b0, srav_res};
      default: ;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept & is_iter),
    .is_div (bus.alu_funct != FUNCT_W'(FN_MUL)),
    .a      (bus.op1),
    .b      (bus.op2),
    .busy   (iter_busy),
    .done   (iter_done),
    .q_prod (iter_q),
    .rem_hi (iter_rem)
  );

  assign iter_res = (funct_reg == FUNCT_W'(FN_REM)) ? iter_rem : iter_q;
  assign iter_ovf = (funct_reg == FUNCT_W'(FN_MUL)) ? (iter_rem != '0) : div0_reg;

  // accept is only possible in IDLE or a consumed DONE, so it takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      alu_res_reg <= '0;
      flags_reg   <= '0;
      funct_reg   <= '0;
      div0_reg    <= 1'b0;
    end else if (accept) begin
      funct_reg <= bus.alu_funct;
      div0_reg  <= (bus.op2 == '0);
      if (is_iter) begin
        state_reg <= ST_BUSY;
      end else begin
        state_reg   <= ST_DONE;
        alu_res_reg <= sc_res;
        flags_reg   <= mk_flags(sc_res[WIDTH-1:0], sc_ovf);
      end
    end else if (state_reg == ST_BUSY) begin
      if (iter_busy & iter_done) begin
        state_reg   <= ST_DONE;
        alu_res_reg <= {1'b0, iter_res};
        flags_reg   <= mk_flags(iter_res, iter_ovf);
      end
    end else if ((state_reg == ST_DONE) & bus.out_ready) begin
      state_reg <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: the driver queues expected results, a negedge
// monitor pops and compares each delivered result.
module tb_alu_mc;
  import alu_mc_pkg::*;

  typedef struct {
    logic [32:0] res;
    logic [4:0]  flags;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  alu_mc_if #(.WIDTH(32), .FUNCT_W(6)) bus ();

  alu_mc #(.WIDTH(32), .FUNCT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_result: got res=%h flags=%b with nothing outstanding", bus.alu_res, bus.flags);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.alu_res !== mon_e.res || bus.flags !== mon_e.flags) begin
          errors++;
          $display("FAIL %s: got res=%h flags=%b, expected res=%h flags=%b",
                   mon_e.name, bus.alu_res, bus.flags, mon_e.res, mon_e.flags);
        end else begin
          $display("ok   %s: res=%h flags=%b", mon_e.name, bus.alu_res, bus.flags);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, expv);
    end else begin
      $display("ok   %s: %0h", nm, got);
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] er, input logic [4:0] ef, input string nm, input bit push);
    exp_t x;
    int   n;
    bus.alu_funct = f;
    bus.op1       = a;
    bus.op2       = b;
    bus.in_valid  = 1'b1;
    if (push) begin
      x.res   = er;
      x.flags = ef;
      x.name  = nm;
      exp_q.push_back(x);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready never rose within 200 cycles", nm);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int c1, c2;
    bit bad, seen;
    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.alu_funct = '0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_alu_res", bus.alu_res, 0);
    chk("reset_flags", bus.flags, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", bus.in_ready, 1);

    issue(FN_ADD, 32'h7FFFFFFF, 32'h1, 33'h0_8000_0000, 5'b11110, "add_ovf", 1);
    chk("add_latency_1", bus.out_valid, 1);
    issue(FN_SUB, 32'd5, 32'd5, 33'h0, 5'b10011, "sub_zero", 1);
    issue(FN_ADD, 32'hFFFFFFFF, 32'h1, 33'h1_0000_0000, 5'b10011, "add_carry", 1);
    issue(FN_SUB, 32'h0, 32'h1, 33'h1_FFFF_FFFF, 5'b10110, "sub_borrow", 1);
    issue(FN_ASR, 32'h80000000, 32'h0, 33'h0_C000_0000, 5'b10110, "asr", 1);
    issue(FN_LSR, 32'h80000000, 32'h0, 33'h0_4000_0000, 5'b00010, "lsr", 1);
    issue(FN_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 33'h0_00F0_00F0, 5'b00010, "and", 1);
    issue(FN_XNOR, 32'h0, 32'h0, 33'h0_FFFF_FFFF, 5'b10110, "xnor", 1);
    issue(FN_NOT, 32'h0000FFFF, 32'h0, 33'h0_FFFF_0000, 5'b10110, "not", 1);
    issue(FN_SLT, 32'hFFFFFFFF, 32'h1, 33'h1, 5'b00010, "slt", 1);
    issue(6'h3F, 32'h1234, 32'h5678, 33'h0, 5'b10011, "unknown_fn", 1);
    issue(FN_SRAV, 32'h80000000, 32'd31, 33'h0_FFFF_FFFF, 5'b10110, "srav31", 1);
    issue(FN_SHLV, 32'h1, 32'd32, 33'h1, 5'b00010, "shlv32", 1);

    issue(FN_MUL, 32'd12345, 32'd1000, 33'd12345000, 5'b00010, "mul", 1);
    bad = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("mul_busy_in_ready_low", bad, 0);
    chk("mul_latency_33", bus.out_valid, 1);
    issue(FN_MUL, 32'h10000, 32'h10000, 33'h0, 5'b11011, "mul_ovf", 1);

    issue(FN_DIV, 32'd100, 32'd7, 33'd14, 5'b00010, "div", 1);
    c1 = acc_cyc;
    issue(FN_REM, 32'd100, 32'd7, 33'd2, 5'b00010, "rem", 1);
    c2 = acc_cyc;
    chk("b2b_accept_gap", c2 - c1, 33);
    issue(FN_DIV, 32'd5, 32'd0, 33'h0_FFFF_FFFF, 5'b11110, "div_by_0", 1);
    issue(FN_REM, 32'd5, 32'd0, 33'd5, 5'b01010, "rem_by_0", 1);
    drain();

    bus.out_ready = 1'b0;
    issue(FN_ADD, 32'd3, 32'd4, 33'd7, 5'b00010, "add_hold", 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_res", bus.alu_res, 7);
      chk("hold_flags", bus.flags, 5'b00010);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    issue(FN_MUL, 32'hFFFF, 32'hFFFF, 33'h0, 5'b0, "mul_abort", 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_late_valid", seen, 0);
    chk("abort_in_ready", bus.in_ready, 1);

    issue(FN_ADD, 32'd1, 32'd1, 33'd2, 5'b00010, "add_after_abort", 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
